// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_pkg
//  Purpose  : Shared geometry, widths, FSM state type and sample/weight types
//             for the 3x3 convolution sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package cnn_pkg;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int AW    = 10;
    localparam int WW    = 8;
    localparam int OW    = 16;

    // Output map geometry: one result per valid 3x3 window position
    localparam int OUT_W = IMG_W - 2;
    localparam int OUT_N = (IMG_W - 2) * (IMG_H - 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef logic [1:0]           sample_t;
    typedef logic signed [WW-1:0] weight_t;

endpackage : cnn_pkg
`default_nettype wire

// File: rtl/cnn_mac9.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_mac9
//  Purpose  : Two-stage 3x3 MAC datapath. Stage 1 registers the nine
//             sample x weight products; stage 2 sums them with the bias,
//             saturates to OW bits and optionally applies ReLU.
//  Revision : 1.0  initial release
// ============================================================================
module cnn_mac9
    import cnn_pkg::*;
#(
    parameter int WW   = 8,
    parameter int OW   = 16,
    parameter bit RELU = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  sample_t [8:0]        win,
    input  logic    [8:0][WW-1:0] weight,
    input  logic signed [OW-1:0] bias,
    output logic signed [OW-1:0] out_data
);

    // Product of an unsigned 2-bit sample and a signed WW-bit weight
    localparam int c_pw = WW + 2;
    // Accumulator width: OW + 2 leaves headroom for bias plus products
    localparam int c_sw = OW + 2;

    localparam logic signed [c_sw-1:0] c_max = {3'b000, {(OW-1){1'b1}}};
    localparam logic signed [c_sw-1:0] c_min = {3'b111, {(OW-1){1'b0}}};

    logic signed [c_pw-1:0] r_prod [9];
    logic signed [c_pw-1:0] w_smp_ext [9];
    logic signed [c_pw-1:0] w_wgt_ext [9];
    logic signed [c_pw-1:0] w_prod [9];
    logic signed [c_sw-1:0] w_sum;
    logic signed [OW-1:0]   w_sat;
    logic signed [OW-1:0]   w_res;

    for (genvar k = 0; k < 9; k++) begin : g_prod
        assign w_smp_ext[k] = c_pw'($signed({1'b0, win[k]}));
        assign w_wgt_ext[k] = c_pw'($signed(weight[k]));
        assign w_prod[k]    = w_smp_ext[k] * w_wgt_ext[k];

        // Stage 1: product register, held while the pipeline is stalled
        always_ff @(posedge clk) begin
            if (rst) begin
                r_prod[k] <= '0;
            end else if (en) begin
                r_prod[k] <= w_prod[k];
            end
        end
    end

    // Adder tree: sign-extended products accumulated onto the bias
    always_comb begin
        w_sum = {{(c_sw-OW){bias[OW-1]}}, bias};
        for (int k = 0; k < 9; k++) begin
            w_sum = w_sum + {{(c_sw-c_pw){r_prod[k][c_pw-1]}}, r_prod[k]};
        end
    end

    // Saturate to the OW-bit signed range, then optional ReLU
    always_comb begin
        if (w_sum > c_max) begin
            w_sat = c_max[OW-1:0];
        end else if (w_sum < c_min) begin
            w_sat = c_min[OW-1:0];
        end else begin
            w_sat = w_sum[OW-1:0];
        end
        w_res = w_sat;
        if (RELU && w_sat[OW-1]) begin
            w_res = '0;
        end
    end

    // Stage 2: result register, held while the pipeline is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
        end else if (en) begin
            out_data <= w_res;
        end
    end

endmodule : cnn_mac9
`default_nettype wire

// File: rtl/cnn_conv3x3_seq.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_conv3x3_seq
//  Purpose  : Sweeps the image RAM read address over every 3x3 window
//             position, feeds the returned window into the MAC pipeline and
//             streams one result per window over a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module cnn_conv3x3_seq
    import cnn_pkg::*;
#(
    parameter int IMG_W = cnn_pkg::IMG_W,
    parameter int IMG_H = cnn_pkg::IMG_H,
    parameter int AW    = cnn_pkg::AW,
    parameter int WW    = cnn_pkg::WW,
    parameter int OW    = cnn_pkg::OW,
    parameter bit RELU  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         addr_rd,
    input  sample_t [8:0]         win,
    input  logic [8:0][WW-1:0]    weight,
    input  logic signed [OW-1:0]  bias,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [OW-1:0]  out_data,
    output logic [AW-1:0]         out_idx
);

    localparam int c_col_w = $clog2(IMG_W);
    localparam int c_row_w = $clog2(IMG_H);

    localparam logic [c_col_w-1:0] c_col_first = c_col_w'(2);
    localparam logic [c_col_w-1:0] c_col_last  = c_col_w'(IMG_W - 1);
    localparam logic [c_row_w-1:0] c_row_first = c_row_w'(2);
    localparam logic [c_row_w-1:0] c_row_last  = c_row_w'(IMG_H - 1);
    localparam logic [AW-1:0]      c_addr_first = AW'(2 * IMG_W + 2);
    localparam logic [AW-1:0]      c_idx_last   = AW'((IMG_W - 2) * (IMG_H - 2) - 1);
    // Moving from the last column to column 2 of the next row skips two pixels
    localparam logic [AW-1:0]      c_step_wrap  = AW'(3);
    localparam logic [AW-1:0]      c_step_col   = AW'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_row_w-1:0]   r_row;
    logic [c_col_w-1:0]   r_col;
    logic [AW-1:0]        r_addr;
    logic [AW-1:0]        r_issue_idx;
    logic                 r_v1;
    logic [AW-1:0]        r_idx1;
    logic                 r_done;
    logic                 w_stall;
    logic                 w_adv;
    logic                 w_issue;
    logic                 w_col_wrap;
    logic                 w_last_issue;
    logic                 w_xfer;
    logic                 w_last_xfer;

    // A held result freezes the whole pipeline and the address sweep
    assign w_stall      = out_valid && !out_ready;
    assign w_adv        = !w_stall;
    assign w_col_wrap   = (r_col == c_col_last);
    assign w_last_issue = w_col_wrap && (r_row == c_row_last);
    assign w_xfer       = out_valid && out_ready;
    assign w_last_xfer  = w_xfer && (out_idx == c_idx_last);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)                    w_state_nxt = ST_RUN;
            ST_RUN:   if (w_issue && w_last_issue)  w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_last_xfer)              w_state_nxt = ST_IDLE;
            default:                                w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: busy flag and per-cycle address issue strobe
    always_comb begin
        busy    = (r_state != ST_IDLE);
        w_issue = (r_state == ST_RUN) && w_adv;
    end

    // Window position counters and the RAM address that tracks them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row       <= '0;
            r_col       <= '0;
            r_addr      <= '0;
            r_issue_idx <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_row       <= c_row_first;
            r_col       <= c_col_first;
            r_addr      <= c_addr_first;
            r_issue_idx <= '0;
        end else if (w_issue && !w_last_issue) begin
            r_issue_idx <= r_issue_idx + 1'b1;
            if (w_col_wrap) begin
                r_col  <= c_col_first;
                r_row  <= r_row + 1'b1;
                r_addr <= r_addr + c_step_wrap;
            end else begin
                r_col  <= r_col + 1'b1;
                r_addr <= r_addr + c_step_col;
            end
        end
    end

    assign addr_rd = r_addr;

    // Valid and index travel alongside the MAC data through both stages
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1      <= 1'b0;
            r_idx1    <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else if (w_adv) begin
            r_v1      <= w_issue;
            r_idx1    <= r_issue_idx;
            out_valid <= r_v1;
            if (r_v1) begin
                out_idx <= r_idx1;
            end
        end
    end

    // Completion pulse in the cycle after the final result is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_last_xfer;
        end
    end

    assign done = r_done;

    cnn_mac9 #(
        .WW   (WW),
        .OW   (OW),
        .RELU (RELU)
    ) u_mac9 (
        .clk      (clk),
        .rst      (rst),
        .en       (w_adv),
        .win      (win),
        .weight   (weight),
        .bias     (bias),
        .out_data (out_data)
    );

endmodule : cnn_conv3x3_seq
`default_nettype wire

// File: tb/tb_cnn_conv3x3_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cnn_conv3x3_seq
//  Purpose  : Self-checking bench for cnn_conv3x3_seq. A RAM model answers
//             the read address with the 3x3 window; results are compared
//             against a direct convolution of the stored image.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cnn_conv3x3_seq;
    import cnn_pkg::*;

    localparam int LIMIT = 4000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 out_ready;
    logic [8:0][WW-1:0]   weight;
    logic signed [OW-1:0] bias;
    sample_t [8:0]        win;
    logic [1:0]           img [IMG_W*IMG_H];

    logic                 busy, done, out_valid;
    logic [AW-1:0]        addr_rd, out_idx;
    logic signed [OW-1:0] out_data;

    logic                 nr_busy, nr_done, nr_valid;
    logic [AW-1:0]        nr_addr, nr_idx;
    logic signed [OW-1:0] nr_data;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // RAM model: window element k sits (2-k/3) rows and (2-k%3) cols before addr
    for (genvar k = 0; k < 9; k++) begin : g_win
        int a;
        assign a      = int'(addr_rd) - (2 - k / 3) * IMG_W - (2 - k % 3);
        assign win[k] = (a >= 0 && a < IMG_W * IMG_H) ? img[a] : 2'd0;
    end

    cnn_conv3x3_seq #(.RELU(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .addr_rd(addr_rd), .win(win), .weight(weight), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx)
    );

    cnn_conv3x3_seq #(.RELU(1'b0)) dut_nr (
        .clk(clk), .rst(rst), .start(start), .busy(nr_busy), .done(nr_done),
        .addr_rd(nr_addr), .win(win), .weight(weight), .bias(bias),
        .out_valid(nr_valid), .out_ready(out_ready),
        .out_data(nr_data), .out_idx(nr_idx)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Direct 3x3 convolution of the stored image at output position idx
    function automatic longint ref_out(input int idx, input bit relu);
        longint s;
        int orow, ocol;
        orow = idx / OUT_W;
        ocol = idx % OUT_W;
        s = longint'(bias);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                s += longint'(img[(orow + r) * IMG_W + ocol + c]) *
                     longint'($signed(weight[r * 3 + c]));
            end
        end
        if (s > (64'sd1 <<< (OW - 1)) - 1) s = (64'sd1 <<< (OW - 1)) - 1;
        if (s < -(64'sd1 <<< (OW - 1)))    s = -(64'sd1 <<< (OW - 1));
        if (relu && s < 0) s = 0;
        return s;
    endfunction

    function automatic int exp_addr(input int k);
        return (k / OUT_W + 2) * IMG_W + (k % OUT_W) + 2;
    endfunction

    task automatic fill_img(input int mode);
        for (int i = 0; i < IMG_W * IMG_H; i++) begin
            img[i] = (mode == 0) ? 2'd0 : (mode == 3) ? 2'd3 : 2'($urandom);
        end
    endtask

    task automatic set_weights(input int w);
        for (int k = 0; k < 9; k++) weight[k] = WW'(w);
    endtask

    task automatic rand_weights();
        for (int k = 0; k < 9; k++) weight[k] = WW'($urandom);
    endtask

    // Runs one frame; negative stall_at/rst_at/start_at disable that event
    task automatic run_frame(input int stall_at, input int rst_at, input int start_at,
                             input bit rnd_ready, input bit chk_addr);
        int exp_idx    = 0;
        int cyc        = 0;
        int stall_left = 0;
        bit stall_done = 1'b0;
        bit start_sent = 1'b0;
        bit got_done   = 1'b0;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        while (1) begin
            start = 1'b0;
            if (cyc >= LIMIT) begin
                check("frame_timeout", cyc, 0);
                break;
            end
            if (cyc == 0) begin
                check("busy_after_start", busy, 1);
                check("addr_first", addr_rd, 58);
            end
            if (chk_addr && cyc < OUT_N) check("addr_seq", addr_rd, exp_addr(cyc));
            if (done) begin
                check("done_after_last", exp_idx, OUT_N);
                check("busy_low_at_done", busy, 0);
                got_done = 1'b1;
                break;
            end
            if (rst_at >= 0 && exp_idx == rst_at && out_valid) begin
                out_ready = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_valid", out_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_idx", out_idx, 0);
                check("rst_addr", addr_rd, 0);
                repeat (5) begin
                    @(negedge clk);
                    check("rst_no_done", done, 0);
                end
                return;
            end
            if (stall_left > 0 || (exp_idx == stall_at && out_valid && !stall_done)) begin
                if (!stall_done) stall_left = 10;
                stall_done = 1'b1;
                stall_left--;
                out_ready = 1'b0;
                check("stall_valid", out_valid, 1);
                check("stall_idx", out_idx, exp_idx);
                check("stall_data", out_data, ref_out(exp_idx, 1'b1));
                check("stall_addr", addr_rd, exp_addr(exp_idx + 2));
            end else begin
                out_ready = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
            end
            if (start_at >= 0 && exp_idx == start_at && !start_sent) begin
                start = 1'b1;
                start_sent = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (exp_idx >= OUT_N) begin
                    check("extra_result", exp_idx, OUT_N - 1);
                    break;
                end
                check("out_idx", out_idx, exp_idx);
                check("out_data", out_data, ref_out(exp_idx, 1'b1));
                check("out_data_norelu", nr_data, ref_out(exp_idx, 1'b0));
                exp_idx++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (got_done) begin
            repeat (3) begin
                @(negedge clk);
                check("single_done", done, 0);
                check("idle_valid", out_valid, 0);
                check("idle_busy", busy, 0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        bias = '0;
        set_weights(0);
        fill_img(0);
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, 0);
        check("reset_idx", out_idx, 0);
        check("reset_addr", addr_rd, 0);
        rst = 1'b0;
        @(negedge clk);

        // Zero image: every result equals the bias; address sweep checked
        rand_weights();
        bias = 16'sd5;
        run_frame(-1, -1, -1, 1'b0, 1'b1);

        // Uniform image of 3s with unit weights
        fill_img(3);
        set_weights(1);
        bias = -16'sd10;
        run_frame(-1, -1, -1, 1'b0, 1'b0);
        weight[4] = WW'(-20);
        run_frame(-1, -1, -1, 1'b1, 1'b0);

        // Saturation at both ends
        set_weights(127);
        bias = 16'sd32767;
        run_frame(-1, -1, -1, 1'b0, 1'b0);
        set_weights(-128);
        bias = -16'sd32768;
        run_frame(-1, -1, -1, 1'b1, 1'b0);

        // Random image with a 10-cycle backpressure window at idx 100
        fill_img(1);
        rand_weights();
        bias = OW'($urandom_range(4000)) - 16'sd2000;
        run_frame(100, -1, -1, 1'b0, 1'b0);

        // Reset mid-frame, then a clean restart with random backpressure
        rand_weights();
        run_frame(-1, 300, -1, 1'b1, 1'b0);
        fill_img(1);
        run_frame(-1, -1, -1, 1'b1, 1'b0);

        // Start pulse during RUN must not disturb the frame
        rand_weights();
        bias = OW'($urandom);
        run_frame(-1, -1, 200, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_cnn_conv3x3_seq
`default_nettype wire
